prng_byte_streamer: RTL and testbench
=====================================

Name: prng_byte_streamer

Overview:
- Seeded 32-bit pseudo-random number generator with a byte-serial output.
- Each get_random request advances the generator one step, then streams the new 32-bit word out on an 8-bit bus, least-significant byte first, one byte per clock over 4 cycles.
- Top-level block (prng_top) feeding consumers that assemble 32-bit random words bytewise.
- Sequence is fully deterministic from SEED; a golden word list is generated offline from the same algorithm.

Parameters:
- SEED, 32'h02468ACD, generator state loaded on reset; must be nonzero.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  reset: asynchronous, active-high; clock clk.
- get_random  input  1  request pulse for a new 32-bit word; sampled on rising clk.
- data_out  output  8  current output byte, registered.

Behaviour:
- Reset (rstn asserted, async): state <= SEED, byte counter <= 0, busy <= 0, data_out <= 8'h00. Sequence restarts from the first word after every reset, including reset mid-stream.
- Generator step (xorshift32, 32-bit wrap): x ^= x<<13; x ^= x>>17; x ^= x<<5. Logical shifts, truncated to 32 bits.
- Idle and get_random=1 at a rising edge:
  - state <= step(state).
  - data_out <= step(state)[7:0].
  - busy <= 1, counter <= 1.
- Busy, at the next three edges: data_out <= state[15:8], then [23:16], then [31:24]. counter increments 1 -> 2 -> 3.
- Busy, at the edge after byte 3: busy <= 0, data_out <= 8'h00.
- Latency:
  - byte0 is valid right after the edge that samples get_random.
  - Bytes are on consecutive cycles.
  - Minimum request spacing is 5 cycles: 4 busy cycles plus 1 idle cycle.
- get_random while busy: ignored. No queuing; the state does not advance.
- get_random held high: treated as a fresh request at the first idle edge, i.e. one word per 5 cycles.
- Consumer assembly: word = (word>>8) ^ {data_out,24'd0} over 4 cycles, which yields the generated word.

Decomposition:
- Package prng_pkg: SEED_DEFAULT = 32'h02468ACD, WORD_W = 32, BYTE_W = 8, BYTES_PER_WORD = 4, xorshift shift constants 13/17/5.
- Sub-module prng_xorshift32: purely combinational next-state function (in 32 -> out 32).
- prng_top holds the state register, byte counter/busy flag and output register.

Test Plan:
- Reset then single get_random pulse -> data_out bytes 8'h02, 8'h2B, 8'hF7, 8'hB0 on 4 consecutive cycles, assembling to word 32'hB0F72B02, then 8'h00.
- Pulse get_random every 5 cycles for 100 requests -> each assembled word equals the golden xorshift32 sequence from SEED; no gaps or skips.
- get_random asserted during busy cycles 1-3 -> ignored; the next word is still step(previous) once a request is made while idle.
- get_random held high continuously -> one new word every 5 cycles, matching the golden sequence.
- Reset asserted mid-stream (e.g. during byte 2) -> data_out = 8'h00 immediately (async); the first request after reset produces 32'hB0F72B02 again.
- Parameter override SEED = 32'h00000001 -> first word 32'h00042021; matches the offline model.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared constants and types for the byte-serial xorshift32 generator.
//   WORD_W / BYTE_W / BYTES_PER_WORD : word, byte and stream geometry
//   SHIFT_A/B/C                      : xorshift32 shift amounts (13, 17, 5)
//   SEED_DEFAULT                     : generator state loaded on reset
package prng_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned SHIFT_A        = 13;
    localparam int unsigned SHIFT_B        = 17;
    localparam int unsigned SHIFT_C        = 5;

    localparam logic [WORD_W-1:0] SEED_DEFAULT = 32'h02468ACD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/prng_byte_streamer_if.sv
// Request/byte-stream bus between a consumer and prng_byte_streamer.
//   get_random : request pulse for a new 32-bit word (consumer -> generator)
//   data_out   : registered output byte, LSB first (generator -> consumer)
interface prng_byte_streamer_if;
    import prng_pkg::*;

    logic              get_random;
    logic [BYTE_W-1:0] data_out;

    modport master (output get_random, input data_out);
    modport slave  (input get_random, output data_out);

endinterface

// File: rtl/prng_xorshift32.sv
// Combinational xorshift32 next-state function (logical shifts, 32-bit wrap).
//   x_i      : current generator state
//   x_next_c : state after one xorshift32 step
module prng_xorshift32
    import prng_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] x_next_c
);

    logic [WORD_W-1:0] t1;
    logic [WORD_W-1:0] t2;

    assign t1       = x_i ^ (x_i << SHIFT_A);
    assign t2       = t1 ^ (t1 >> SHIFT_B);
    assign x_next_c = t2 ^ (t2 << SHIFT_C);

endmodule

// File: rtl/prng_byte_streamer.sv
// Seeded xorshift32 generator streaming each new word LSB-first, one byte
// per clock, over four cycles, followed by one idle cycle with data_out = 0.
//   clk  : clock, all state on rising edge
//   rstn : asynchronous reset, ACTIVE-HIGH despite the name
//   bus  : slave side of prng_byte_streamer_if (get_random in, data_out out)
// Requests arriving while a word is streaming are dropped, not queued.
module prng_byte_streamer
    import prng_pkg::*;
#(
    parameter logic [WORD_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    prng_byte_streamer_if.slave   bus
);

    state_e              fsm_q,  fsm_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   word_next_c;

    prng_xorshift32 u_step (
        .x_i      (word_q),
        .x_next_c (word_next_c)
    );

    // State register; reset restarts the sequence from SEED.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fsm_q  <= ST_IDLE;
            word_q <= SEED;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    // Next-state: accept a request when idle, then walk bytes 1..3, then idle.
    always_comb begin
        fsm_d  = fsm_q;
        word_d = word_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        unique case (fsm_q)
            ST_IDLE: begin
                data_d = '0;
                if (bus.get_random) begin
                    fsm_d  = ST_BUSY;
                    word_d = word_next_c;
                    data_d = word_next_c[BYTE_W-1:0];
                    cnt_d  = CNT_W'(1);
                end
            end
            ST_BUSY: begin
                // cnt_q counts bytes already presented; after the last one
                // spend one cycle idle so requests are at least 5 cycles apart.
                if (cnt_q == CNT_W'(BYTES_PER_WORD)) begin
                    fsm_d  = ST_IDLE;
                    cnt_d  = '0;
                    data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (cnt_q)
                        CNT_W'(1): data_d = word_q[15:8];
                        CNT_W'(2): data_d = word_q[23:16];
                        default:   data_d = word_q[31:24];
                    endcase
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out = data_q;

endmodule

// File: tb/tb_prng_byte_streamer.sv
// Self-checking bench for prng_byte_streamer: scoreboard of expected words
// from an independent xorshift32 model, compared against bytewise assembly.
module tb_prng_byte_streamer;

    localparam logic [31:0] SEED0 = 32'h02468ACD;
    localparam logic [31:0] SEED1 = 32'h00000001;

    logic clk = 1'b0;
    logic rstn;

    prng_byte_streamer_if if0 ();
    prng_byte_streamer_if if1 ();

    prng_byte_streamer dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    prng_byte_streamer #(.SEED(SEED1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] m0;
    logic [31:0] m1;

    function automatic logic [31:0] model_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Called at the negedge right after the sampling edge. Assembles four
    // bytes, optionally raising get_random on if0 during busy cycles 1-3,
    // and returns the byte seen at the following (idle) cycle.
    task automatic collect(input bit use1, input bit poke,
                           output logic [31:0] w, output logic [7:0] tail);
        logic [7:0] b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = use1 ? if1.data_out : if0.data_out;
            w = (w >> 8) ^ {b, 24'd0};
            if (poke) if0.get_random = (i < 3);
            @(negedge clk);
        end
        tail = use1 ? if1.data_out : if0.data_out;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        if0.get_random = 1'b0;
        if1.get_random = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        m0 = SEED0;
        m1 = SEED1;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        if0.get_random = 1'b0;
        if1.get_random = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout0: got %h want 00", if0.data_out);
        end
        checks++;
        if (if1.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout1: got %h want 00", if1.data_out);
        end
        rstn = 1'b0;
        m0 = SEED0;
        m1 = SEED1;
        sb.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_dout: got %h want 00", if0.data_out);
        end
    endtask

    task automatic test_single();
        logic [31:0] w, exp;
        logic [7:0]  tail;
        m0 = model_step(m0);
        sb.push_back(m0);
        if0.get_random = 1'b1;
        @(negedge clk);
        if0.get_random = 1'b0;
        collect(1'b0, 1'b0, w, tail);
        exp = sb.pop_front();
        checks++;
        if (w !== exp) begin
            errors++;
            $display("FAIL single_model: got %h want %h", w, exp);
        end
        checks++;
        if (w !== 32'hB0F72B02) begin
            errors++;
            $display("FAIL single_golden: got %h want b0f72b02", w);
        end
        checks++;
        if (tail !== 8'h00) begin
            errors++;
            $display("FAIL single_tail: got %h want 00", tail);
        end
    endtask

    task automatic test_sequence(input int n);
        logic [31:0] w, exp;
        logic [7:0]  tail;
        for (int k = 0; k < n; k++) begin
            m0 = model_step(m0);
            sb.push_back(m0);
            if0.get_random = 1'b1;
            @(negedge clk);
            if0.get_random = 1'b0;
            collect(1'b0, 1'b0, w, tail);
            exp = sb.pop_front();
            checks++;
            if (w !== exp) begin
                errors++;
                $display("FAIL seq_word[%0d]: got %h want %h", k, w, exp);
            end
            checks++;
            if (tail !== 8'h00) begin
                errors++;
                $display("FAIL seq_tail[%0d]: got %h want 00", k, tail);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] w, exp;
        logic [7:0]  tail;
        for (int k = 0; k < 2; k++) begin
            m0 = model_step(m0);
            sb.push_back(m0);
            if0.get_random = 1'b1;
            @(negedge clk);
            if0.get_random = 1'b0;
            collect(1'b0, (k == 0), w, tail);
            exp = sb.pop_front();
            checks++;
            if (w !== exp) begin
                errors++;
                $display("FAIL ignore_word[%0d]: got %h want %h", k, w, exp);
            end
            checks++;
            if (tail !== 8'h00) begin
                errors++;
                $display("FAIL ignore_tail[%0d]: got %h want 00", k, tail);
            end
        end
        // Nothing requested now: output must stay at zero.
        repeat (3) @(negedge clk);
        checks++;
        if (if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL ignore_quiet: got %h want 00", if0.data_out);
        end
    endtask

    task automatic test_held_high();
        logic [31:0] w, exp;
        logic [7:0]  tail;
        if0.get_random = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m0 = model_step(m0);
            sb.push_back(m0);
            @(negedge clk);
            collect(1'b0, 1'b0, w, tail);
            exp = sb.pop_front();
            checks++;
            if (w !== exp) begin
                errors++;
                $display("FAIL held_word[%0d]: got %h want %h", k, w, exp);
            end
            checks++;
            if (tail !== 8'h00) begin
                errors++;
                $display("FAIL held_tail[%0d]: got %h want 00", k, tail);
            end
        end
        if0.get_random = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL held_release: got %h want 00", if0.data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, exp, first;
        logic [7:0]  tail;
        do_reset();
        first = model_step(SEED0);
        if0.get_random = 1'b1;
        @(negedge clk);
        if0.get_random = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if0.data_out !== first[23:16]) begin
            errors++;
            $display("FAIL mid_byte2: got %h want %h", if0.data_out, first[23:16]);
        end
        #2 rstn = 1'b1;
        #1;
        checks++;
        if (if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_async: got %h want 00", if0.data_out);
        end
        @(negedge clk);
        rstn = 1'b0;
        m0 = SEED0;
        m1 = SEED1;
        sb.delete();
        @(negedge clk);
        m0 = model_step(m0);
        sb.push_back(m0);
        if0.get_random = 1'b1;
        @(negedge clk);
        if0.get_random = 1'b0;
        collect(1'b0, 1'b0, w, tail);
        exp = sb.pop_front();
        checks++;
        if (w !== 32'hB0F72B02 || w !== exp) begin
            errors++;
            $display("FAIL mid_restart: got %h want b0f72b02", w);
        end
    endtask

    task automatic test_seed_override();
        logic [31:0] w, exp;
        logic [7:0]  tail;
        for (int k = 0; k < 3; k++) begin
            m1 = model_step(m1);
            sb.push_back(m1);
            if1.get_random = 1'b1;
            @(negedge clk);
            if1.get_random = 1'b0;
            collect(1'b1, 1'b0, w, tail);
            exp = sb.pop_front();
            checks++;
            if (w !== exp) begin
                errors++;
                $display("FAIL seed1_word[%0d]: got %h want %h", k, w, exp);
            end
            if (k == 0) begin
                checks++;
                if (w !== 32'h00042021) begin
                    errors++;
                    $display("FAIL seed1_golden: got %h want 00042021", w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence(99);
        test_busy_ignore();
        test_held_high();
        test_reset_mid();
        test_seed_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
